write_back_multiport: RTL and testbench

//  Parametrised write-back stage: commits up to NUM_WB results per cycle into the architectural register file.

---
 rtl/write_back_multiport_pkg.sv | 16 +
 rtl/wb_pc_delay_line.sv | 27 ++
 rtl/write_back_multiport.sv | 128 ++++++++++++
 tb/tb_write_back_multiport.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/write_back_multiport_pkg.sv
// rtl/write_back_multiport_pkg.sv - shared constants and types for the write-back stage
package write_back_multiport_pkg;

  localparam int REG_N_DEF = 16;
  localparam int REG_W_DEF = 64;

  // Architectural register indices with fixed roles
  localparam int RSP_IDX = 4;
  localparam int RBP_IDX = 5;
  localparam int RIP_IDX = 14;
  localparam int EFL_IDX = 15;

  typedef logic [REG_W_DEF-1:0] reg_t;
  typedef logic [REG_W_DEF-1:0] addr_t;

endpackage

// File: rtl/wb_pc_delay_line.sv
// rtl/wb_pc_delay_line.sv - PC shift register with hold, aligns fetch PC with memory latency
module wb_pc_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  // Shift one stage per cycle; a hold freezes every stage so the tail replays
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (!hold) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/write_back_multiport.sv
// rtl/write_back_multiport.sv - multi-port register commit, RIP sequencing and post-branch flush
module write_back_multiport
  import write_back_multiport_pkg::*;
#(
  parameter int               NUM_WB            = 2,
  parameter int               REG_N             = REG_N_DEF,
  parameter int               REG_W             = REG_W_DEF,
  parameter int               LOAD_LATENCY      = 1,
  parameter int               FLUSH_LEN         = LOAD_LATENCY,
  parameter bit               SUPPRESS_ON_FLUSH = 1'b1,
  parameter logic [REG_W-1:0] INIT_RIP          = '0,
  parameter logic [REG_W-1:0] INIT_RSP          = REG_W'(1024)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_WB-1:0]                 wb_valid,
  input  logic [NUM_WB*$clog2(REG_N)-1:0]   wb_idx,
  input  logic [NUM_WB*REG_W-1:0]           wb_data,
  input  logic                              efl_we,
  input  logic [REG_W-1:0]                  efl_data,
  input  logic                              br_taken,
  input  logic [REG_W-1:0]                  br_target,
  input  logic                              stall_pc,
  output logic [REG_N*REG_W-1:0]            gpr,
  output logic [REG_W-1:0]                  pc_to_mem,
  output logic [REG_W-1:0]                  pc_to_fet,
  output logic                              flush,
  output logic [31:0]                       commit_cnt
);

  localparam int IDX_W = $clog2(REG_N);
  localparam int FW    = $clog2(FLUSH_LEN + 1);

  // RIP starts LOAD_LATENCY behind INIT_RIP so the first aligned fetch lands on INIT_RIP
  localparam logic [REG_W-1:0] RESET_RIP = INIT_RIP - REG_W'(LOAD_LATENCY);

  logic [REG_W-1:0]  regs [REG_N];
  logic [REG_W-1:0]  rip_nxt;
  logic [FW-1:0]     flush_cnt;
  logic [FW-1:0]     flush_cnt_nxt;
  logic              accept;
  logic              br_acc;
  logic [NUM_WB-1:0] wr_ok;
  logic [31:0]       n_commit;

  // Inputs presented during a flush window are dropped when suppression is enabled
  always_comb begin
    accept = !(SUPPRESS_ON_FLUSH && flush);
    br_acc = br_taken && accept;
  end

  // Per-channel write enable: RIP is owned by PC logic, out-of-range indices are ignored
  always_comb begin
    wr_ok    = '0;
    n_commit = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      wr_ok[k] = wb_valid[k] && accept
                 && (int'(wb_idx[k*IDX_W +: IDX_W]) < REG_N)
                 && (int'(wb_idx[k*IDX_W +: IDX_W]) != RIP_IDX);
      n_commit = n_commit + {31'b0, wr_ok[k]};
    end
  end

  // Next fetch address: an accepted branch beats a stall, a stall replays the aligned PC
  always_comb begin
    if (br_acc)        rip_nxt = br_target;
    else if (stall_pc) rip_nxt = pc_to_fet;
    else               rip_nxt = regs[RIP_IDX] + REG_W'(1);
  end

  // Flush counter reloads on an accepted branch and otherwise counts down to zero
  always_comb begin
    if (br_acc)              flush_cnt_nxt = FW'(FLUSH_LEN);
    else if (flush_cnt != 0) flush_cnt_nxt = flush_cnt - FW'(1);
    else                     flush_cnt_nxt = '0;
  end

  // Register file commit; later channels overwrite earlier ones, EFL write overrides all channels
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      regs[RIP_IDX] <= RESET_RIP;
      regs[RSP_IDX] <= INIT_RSP;
      regs[RBP_IDX] <= INIT_RSP;
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wr_ok[k]) regs[wb_idx[k*IDX_W +: IDX_W]] <= wb_data[k*REG_W +: REG_W];
      end
      if (efl_we && accept) regs[EFL_IDX] <= efl_data;
      regs[RIP_IDX] <= rip_nxt;
    end
  end

  // Flush output is registered from the counter's next value so it rises the cycle after a branch
  always_ff @(posedge clk) begin
    if (!rstn) begin
      flush_cnt <= '0;
      flush     <= 1'b0;
    end else begin
      flush_cnt <= flush_cnt_nxt;
      flush     <= (flush_cnt_nxt != '0);
    end
  end

  // Count every accepted channel write, including ones overwritten by a higher channel
  always_ff @(posedge clk) begin
    if (!rstn) commit_cnt <= '0;
    else       commit_cnt <= commit_cnt + n_commit;
  end

  for (genvar g = 0; g < REG_N; g++) begin : g_gpr
    assign gpr[g*REG_W +: REG_W] = regs[g];
  end

  assign pc_to_mem = regs[RIP_IDX];

  wb_pc_delay_line #(
    .DEPTH (LOAD_LATENCY),
    .W     (REG_W)
  ) u_pc_delay_line (
    .clk  (clk),
    .rstn (rstn),
    .hold (stall_pc),
    .d    (pc_to_mem),
    .q    (pc_to_fet)
  );

endmodule

// File: tb/tb_write_back_multiport.sv
// tb/tb_write_back_multiport.sv - self-checking bench for write_back_multiport
module tb_write_back_multiport;
  import write_back_multiport_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    wb_valid;
  logic [7:0]    wb_idx;
  logic [127:0]  wb_data;
  logic          efl_we;
  logic [63:0]   efl_data;
  logic          br_taken;
  logic [63:0]   br_target;
  logic          stall_pc;

  logic [1023:0] gpr_a, gpr_b;
  logic [63:0]   pc_mem_a, pc_mem_b, pc_fet_a, pc_fet_b;
  logic          flush_a, flush_b;
  logic [31:0]   cnt_a, cnt_b;

  always #5 clk = ~clk;

  write_back_multiport #(
    .NUM_WB(2), .REG_N(16), .REG_W(64), .LOAD_LATENCY(3), .FLUSH_LEN(3),
    .SUPPRESS_ON_FLUSH(1'b1), .INIT_RIP(64'h100), .INIT_RSP(64'd1024)
  ) dut_a (
    .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .efl_we(efl_we), .efl_data(efl_data), .br_taken(br_taken), .br_target(br_target),
    .stall_pc(stall_pc), .gpr(gpr_a), .pc_to_mem(pc_mem_a), .pc_to_fet(pc_fet_a),
    .flush(flush_a), .commit_cnt(cnt_a)
  );

  write_back_multiport #(
    .NUM_WB(2), .REG_N(16), .REG_W(64), .LOAD_LATENCY(2), .FLUSH_LEN(2),
    .SUPPRESS_ON_FLUSH(1'b0), .INIT_RIP(64'h100), .INIT_RSP(64'd1024)
  ) dut_b (
    .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .efl_we(efl_we), .efl_data(efl_data), .br_taken(br_taken), .br_target(br_target),
    .stall_pc(stall_pc), .gpr(gpr_b), .pc_to_mem(pc_mem_b), .pc_to_fet(pc_fet_b),
    .flush(flush_b), .commit_cnt(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the PC path, flush window and commit counter for both instances
  int          ll_of [2] = '{3, 2};
  int          fl_of [2] = '{3, 2};
  bit          sup_of[2] = '{1'b1, 1'b0};
  logic [63:0] m_rip [2];
  logic [63:0] m_q   [2][3];
  int          m_fc  [2];
  logic        m_fl  [2];
  logic [31:0] m_cnt [2];

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  i0;
    logic [63:0] d0;
    logic [3:0]  i1;
    logic [63:0] d1;
    logic        ew;
    logic [63:0] ed;
    int          ci;
    logic [63:0] ev;
    logic [31:0] dc;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [1023:0] g, input int i);
    return g[i*64 +: 64];
  endfunction

  task automatic idle();
    wb_valid  = '0;
    wb_idx    = '0;
    wb_data   = '0;
    efl_we    = 1'b0;
    efl_data  = '0;
    br_taken  = 1'b0;
    br_target = '0;
    stall_pc  = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] da, input logic [31:0] db);
    logic        acc, bra;
    logic [63:0] pcf;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_rip[i] = 64'h100 - 64'(ll_of[i]);
        for (int s = 0; s < 3; s++) m_q[i][s] = '0;
        m_fc[i]  = 0;
        m_fl[i]  = 1'b0;
        m_cnt[i] = '0;
      end else begin
        acc = !(sup_of[i] && m_fl[i]);
        bra = br_taken && acc;
        pcf = m_q[i][ll_of[i]-1];
        if (!stall_pc) begin
          for (int s = ll_of[i] - 1; s > 0; s--) m_q[i][s] = m_q[i][s-1];
          m_q[i][0] = m_rip[i];
        end
        m_rip[i] = bra ? br_target : (stall_pc ? pcf : m_rip[i] + 64'd1);
        m_fc[i]  = bra ? fl_of[i] : (m_fc[i] > 0 ? m_fc[i] - 1 : 0);
        m_fl[i]  = (m_fc[i] != 0);
        m_cnt[i] = m_cnt[i] + ((i == 0) ? da : db);
      end
    end
  endtask

  task automatic check_pc();
    chk("rip_a",    pc_mem_a, m_rip[0]);
    chk("rip_b",    pc_mem_b, m_rip[1]);
    chk("pc_fet_a", pc_fet_a, m_q[0][2]);
    chk("pc_fet_b", pc_fet_b, m_q[1][1]);
    chk("flush_a",  64'(flush_a), 64'(m_fl[0]));
    chk("flush_b",  64'(flush_b), 64'(m_fl[1]));
    chk("cnt_a",    64'(cnt_a), 64'(m_cnt[0]));
    chk("cnt_b",    64'(cnt_b), 64'(m_cnt[1]));
  endtask

  task automatic step(input logic [31:0] da, input logic [31:0] db);
    model_step(da, db);
    @(posedge clk);
    #1;
    check_pc();
  endtask

  initial begin
    logic [63:0] fet_hold;

    tv[0] = '{2'b11, 4'd3, 64'hA, 4'd3, 64'hB, 1'b0, 64'h0, 3, 64'hB, 32'd2};
    tv[1] = '{2'b01, 4'd7, 64'h77, 4'd0, 64'h0, 1'b0, 64'h0, 7, 64'h77, 32'd1};
    tv[2] = '{2'b10, 4'd0, 64'h0, 4'd8, 64'h88, 1'b0, 64'h0, 8, 64'h88, 32'd1};
    tv[3] = '{2'b11, 4'(RIP_IDX), 64'h55, 4'd9, 64'h99, 1'b0, 64'h0, 9, 64'h99, 32'd1};
    tv[4] = '{2'b01, 4'(EFL_IDX), 64'h11, 4'd0, 64'h0, 1'b1, 64'h22, EFL_IDX, 64'h22, 32'd1};
    tv[5] = '{2'b00, 4'd0, 64'h0, 4'd0, 64'h0, 1'b1, 64'h33, EFL_IDX, 64'h33, 32'd0};
    tv[6] = '{2'b11, 4'(RSP_IDX), 64'h1000, 4'(RBP_IDX), 64'h2000, 1'b0, 64'h0, RBP_IDX, 64'h2000, 32'd2};
    tv[7] = '{2'b00, 4'd3, 64'hF0, 4'd3, 64'hF1, 1'b0, 64'h0, 3, 64'hB, 32'd0};
    tv[8] = '{2'b11, 4'd6, 64'hC, 4'(RIP_IDX), 64'h55, 1'b0, 64'h0, 6, 64'hC, 32'd1};

    idle();
    rstn = 1'b0;
    step(0, 0);
    step(0, 0);
    chk("reset_rip_b", rd(gpr_b, RIP_IDX), 64'hFE);
    chk("reset_rip_a", rd(gpr_a, RIP_IDX), 64'hFD);
    chk("reset_rsp",   rd(gpr_b, RSP_IDX), 64'd1024);
    chk("reset_rbp",   rd(gpr_b, RBP_IDX), 64'd1024);
    chk("reset_r3",    rd(gpr_a, 3), 64'h0);
    chk("reset_efl",   rd(gpr_a, EFL_IDX), 64'h0);

    rstn = 1'b1;
    for (int n = 0; n < 9; n++) begin
      wb_valid = tv[n].v;
      wb_idx   = {tv[n].i1, tv[n].i0};
      wb_data  = {tv[n].d1, tv[n].d0};
      efl_we   = tv[n].ew;
      efl_data = tv[n].ed;
      step(tv[n].dc, tv[n].dc);
      idle();
      chk($sformatf("vec%0d_gpr_a", n), rd(gpr_a, tv[n].ci), tv[n].ev);
      chk($sformatf("vec%0d_gpr_b", n), rd(gpr_b, tv[n].ci), tv[n].ev);
    end
    chk("rsp_written", rd(gpr_a, RSP_IDX), 64'h1000);

    // Taken branch together with a stall: branch wins, flush window opens
    br_taken  = 1'b1;
    br_target = 64'h400;
    stall_pc  = 1'b1;
    step(0, 0);
    idle();
    chk("br_rip_a",   rd(gpr_a, RIP_IDX), 64'h400);
    chk("br_rip_b",   rd(gpr_b, RIP_IDX), 64'h400);
    chk("br_flush_a", 64'(flush_a), 64'd1);

    // Write and second branch inside the flush window
    wb_valid  = 2'b01;
    wb_idx    = {4'd0, 4'd10};
    wb_data   = {64'h0, 64'hDEAD};
    br_taken  = 1'b1;
    br_target = 64'h800;
    step(0, 1);
    idle();
    chk("sup_gpr_a",   rd(gpr_a, 10), 64'h0);
    chk("nosup_gpr_b", rd(gpr_b, 10), 64'hDEAD);
    chk("sup_rip_a",   rd(gpr_a, RIP_IDX), 64'h401);
    chk("nosup_rip_b", rd(gpr_b, RIP_IDX), 64'h800);
    step(0, 0);
    chk("flush3_a", 64'(flush_a), 64'd1);
    step(0, 0);
    chk("flush_end_a", 64'(flush_a), 64'd0);
    chk("flush_end_b", 64'(flush_b), 64'd0);

    // Four-cycle fetch stall: aligned PC frozen and replayed into RIP
    fet_hold = m_q[0][2];
    stall_pc = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(0, 0);
      chk($sformatf("stall%0d_fet_a", c), pc_fet_a, fet_hold);
      chk($sformatf("stall%0d_rip_a", c), rd(gpr_a, RIP_IDX), fet_hold);
    end
    stall_pc = 1'b0;
    step(0, 0);
    chk("resume_rip_a", rd(gpr_a, RIP_IDX), fet_hold + 64'd1);

    // Reset in the middle of a flush window
    br_taken  = 1'b1;
    br_target = 64'h200;
    step(0, 0);
    idle();
    chk("pre_rst_flush_a", 64'(flush_a), 64'd1);
    rstn = 1'b0;
    step(0, 0);
    chk("rst_flush_a", 64'(flush_a), 64'd0);
    chk("rst_flush_b", 64'(flush_b), 64'd0);
    chk("rst_rip_b",   rd(gpr_b, RIP_IDX), 64'hFE);
    rstn = 1'b1;
    step(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
